// File: rtl/warp_inst_buffer_if.sv
// ---------------------------------------------------------------------------
// warp_inst_buffer_if
// Bundles every signal between the per-warp instruction buffer and its
// neighbours (fetch, scoreboard, decode, flush sources).
//   master modport : the environment (fetch / scoreboard / decode side)
//   slave  modport : the instruction buffer itself
// Signals:
//   stall_i              global pipeline stall
//   instWarp_i           warp of the incoming fetch pair
//   instPacket{0,1}*_i   entry write requests and {instruction, PC} payloads
//   warpReady_i          per-warp scoreboard permission to issue
//   issueReady_i         decode accepts an issue this cycle
//   reconv_i/reconvWarp_i, ctaExit_i/exitWarp_i  flush requests
//   issue*_o             current issue candidate
//   selected*_o          consumed warp/entry reported back to fetch
//   bufValid_o           {entry1 valids, entry0 valids}
//   overflow_o           sticky write-into-busy-warp flag
// ---------------------------------------------------------------------------
interface warp_inst_buffer_if #(
    parameter int NUM_WARP         = 4,
    parameter int NUM_WARP_LOG     = 2,
    parameter int SIZE_PC          = 32,
    parameter int SIZE_INSTRUCTION = 64
);
    logic                                  stall_i;
    logic [NUM_WARP_LOG-1:0]               instWarp_i;
    logic                                  instPacket0Valid_i;
    logic [SIZE_INSTRUCTION+SIZE_PC-1:0]   instPacket0_i;
    logic                                  instPacket1Valid_i;
    logic [SIZE_INSTRUCTION+SIZE_PC-1:0]   instPacket1_i;
    logic [NUM_WARP-1:0]                   warpReady_i;
    logic                                  issueReady_i;
    logic                                  reconv_i;
    logic [NUM_WARP_LOG-1:0]               reconvWarp_i;
    logic                                  ctaExit_i;
    logic [NUM_WARP_LOG-1:0]               exitWarp_i;

    logic                                  issueValid_o;
    logic [NUM_WARP_LOG-1:0]               issueWarp_o;
    logic [SIZE_INSTRUCTION-1:0]           issueInst_o;
    logic [SIZE_PC-1:0]                    issuePC_o;
    logic                                  selectedPacketValid_o;
    logic [NUM_WARP_LOG-1:0]               selectedWarp_o;
    logic                                  selectedEntry_o;
    logic [2*NUM_WARP-1:0]                 bufValid_o;
    logic                                  overflow_o;

    modport master (
        output stall_i, instWarp_i, instPacket0Valid_i, instPacket0_i,
               instPacket1Valid_i, instPacket1_i, warpReady_i, issueReady_i,
               reconv_i, reconvWarp_i, ctaExit_i, exitWarp_i,
        input  issueValid_o, issueWarp_o, issueInst_o, issuePC_o,
               selectedPacketValid_o, selectedWarp_o, selectedEntry_o,
               bufValid_o, overflow_o
    );

    modport slave (
        input  stall_i, instWarp_i, instPacket0Valid_i, instPacket0_i,
               instPacket1Valid_i, instPacket1_i, warpReady_i, issueReady_i,
               reconv_i, reconvWarp_i, ctaExit_i, exitWarp_i,
        output issueValid_o, issueWarp_o, issueInst_o, issuePC_o,
               selectedPacketValid_o, selectedWarp_o, selectedEntry_o,
               bufValid_o, overflow_o
    );
endinterface

// File: rtl/warp_inst_buffer.sv
// ---------------------------------------------------------------------------
// warp_inst_buffer
// Per-warp two-entry instruction buffer sitting right after fetch.
//   - Captures the {instruction, PC} pair fetched for one warp per cycle.
//   - Picks one ready warp per cycle round-robin and presents its oldest
//     entry (entry0 before entry1) to decode.
//   - Reports the consumed warp/entry back to fetch.
//   - Flushes a warp on reconvergence or CTA exit.
// Ports:
//   clk    rising-edge clock for all state
//   reset  synchronous, active-high
//   bus    warp_inst_buffer_if.slave (see interface header for signals)
// ---------------------------------------------------------------------------
module warp_inst_buffer #(
    parameter int NUM_WARP         = 4,
    parameter int NUM_WARP_LOG     = 2,
    parameter int SIZE_PC          = 32,
    parameter int SIZE_INSTRUCTION = 64
) (
    input  logic                clk,
    input  logic                reset,
    warp_inst_buffer_if.slave   bus
);
    localparam int PKT_W = SIZE_INSTRUCTION + SIZE_PC;

    // State
    logic [NUM_WARP-1:0]     valid0_q, valid0_d;
    logic [NUM_WARP-1:0]     valid1_q, valid1_d;
    logic [NUM_WARP_LOG-1:0] last_warp_q, last_warp_d;
    logic                    overflow_q, overflow_d;

    // Payload storage, intentionally not reset: valid bits qualify it.
    logic [PKT_W-1:0]        ram0 [NUM_WARP];
    logic [PKT_W-1:0]        ram1 [NUM_WARP];

    // Per-warp control
    logic [NUM_WARP-1:0]     busy;
    logic [NUM_WARP-1:0]     flush_hit;
    logic [NUM_WARP-1:0]     eligible;
    logic [NUM_WARP-1:0]     wr_hit;
    logic [NUM_WARP-1:0]     clr0;
    logic [NUM_WARP-1:0]     clr1;

    logic                    write_req;
    logic                    write_en;
    logic                    write_err;
    logic                    fire;
    logic                    any_eligible;
    logic                    head_entry;
    logic [NUM_WARP_LOG-1:0] winner;
    logic [NUM_WARP_LOG-1:0] scan_idx;
    logic [PKT_W-1:0]        head_pkt;

    // -----------------------------------------------------------------------
    // Write qualification. A flush on the target warp silently swallows the
    // write; otherwise a write into a warp that still holds anything is a
    // protocol error. A same-cycle issue to that warp implies it is busy, so
    // that case is covered by the busy check as well.
    // -----------------------------------------------------------------------
    assign write_req = ~bus.stall_i & (bus.instPacket0Valid_i | bus.instPacket1Valid_i);
    assign write_en  = write_req & ~flush_hit[bus.instWarp_i] & ~busy[bus.instWarp_i];
    assign write_err = write_req & ~flush_hit[bus.instWarp_i] &  busy[bus.instWarp_i];

    // -----------------------------------------------------------------------
    // Per-warp eligibility and next valid bits
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_WARP; gi++) begin : g_warp
            assign busy[gi] = valid0_q[gi] | valid1_q[gi];

            // Flushes only act when the pipe is not stalled.
            assign flush_hit[gi] = ~bus.stall_i &
                ((bus.reconv_i  & (bus.reconvWarp_i == NUM_WARP_LOG'(gi))) |
                 (bus.ctaExit_i & (bus.exitWarp_i   == NUM_WARP_LOG'(gi))));

            // A warp being flushed this cycle must not be offered to decode.
            assign eligible[gi] = busy[gi] & bus.warpReady_i[gi] & ~flush_hit[gi];

            assign wr_hit[gi] = write_en & (bus.instWarp_i == NUM_WARP_LOG'(gi));

            assign clr0[gi] = fire & (winner == NUM_WARP_LOG'(gi)) & ~head_entry;
            assign clr1[gi] = fire & (winner == NUM_WARP_LOG'(gi)) &  head_entry;

            // Flush dominates; a write only lands on an empty warp, so it can
            // never coincide with an issue clear on the same warp.
            assign valid0_d[gi] = ~flush_hit[gi] &
                ((wr_hit[gi] & bus.instPacket0Valid_i) | (valid0_q[gi] & ~clr0[gi]));
            assign valid1_d[gi] = ~flush_hit[gi] &
                ((wr_hit[gi] & bus.instPacket1Valid_i) | (valid1_q[gi] & ~clr1[gi]));
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Round-robin pick: first eligible warp at last_warp+1, +2, ... wrapping.
    // The final offset (NUM_WARP) truncates back to last_warp itself.
    // -----------------------------------------------------------------------
    always_comb begin
        winner       = '0;
        any_eligible = 1'b0;
        scan_idx     = '0;
        for (int k = 1; k <= NUM_WARP; k++) begin
            scan_idx = last_warp_q + NUM_WARP_LOG'(k);
            if (!any_eligible && eligible[scan_idx]) begin
                any_eligible = 1'b1;
                winner       = scan_idx;
            end
        end
    end

    // Head entry of the winner: entry0 whenever it is still valid.
    assign head_entry = ~valid0_q[winner];
    assign head_pkt   = head_entry ? ram1[winner] : ram0[winner];

    assign fire = any_eligible & bus.issueReady_i & ~bus.stall_i;

    // -----------------------------------------------------------------------
    // Next-state for pointer and sticky error
    // -----------------------------------------------------------------------
    always_comb begin
        last_warp_d = last_warp_q;
        overflow_d  = overflow_q | write_err;
        if (fire) begin
            last_warp_d = winner;
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            valid0_q    <= '0;
            valid1_q    <= '0;
            last_warp_q <= NUM_WARP_LOG'(NUM_WARP - 1);
            overflow_q  <= 1'b0;
        end else begin
            valid0_q    <= valid0_d;
            valid1_q    <= valid1_d;
            last_warp_q <= last_warp_d;
            overflow_q  <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int w = 0; w < NUM_WARP; w++) begin
            if (wr_hit[w] && bus.instPacket0Valid_i) begin
                ram0[w] <= bus.instPacket0_i;
            end
            if (wr_hit[w] && bus.instPacket1Valid_i) begin
                ram1[w] <= bus.instPacket1_i;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.issueValid_o          = any_eligible;
    assign bus.issueWarp_o           = winner;
    assign bus.issueInst_o           = head_pkt[SIZE_PC +: SIZE_INSTRUCTION];
    assign bus.issuePC_o             = head_pkt[SIZE_PC-1:0];
    assign bus.selectedPacketValid_o = fire;
    assign bus.selectedWarp_o        = fire ? winner : '0;
    assign bus.selectedEntry_o       = fire & head_entry;
    assign bus.bufValid_o            = {valid1_q, valid0_q};
    assign bus.overflow_o            = overflow_q;

endmodule

// File: tb/tb_warp_inst_buffer.sv
module tb_warp_inst_buffer;
    typedef struct packed {
        logic [1:0]  warp;
        logic        entry;
        logic [31:0] pc;
        logic [63:0] inst;
    } rec_t;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp  = 0;
    int   n_fail = 0;
    rec_t exp_q[$];
    rec_t obs_q[$];

    always #5 clk = ~clk;

    warp_inst_buffer_if #(.NUM_WARP(4), .NUM_WARP_LOG(2), .SIZE_PC(32), .SIZE_INSTRUCTION(64)) bif();

    warp_inst_buffer #(.NUM_WARP(4), .NUM_WARP_LOG(2), .SIZE_PC(32), .SIZE_INSTRUCTION(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif.slave)
    );

    function automatic logic [63:0] mk_inst(input logic [31:0] pc);
        return {pc ^ 32'hDEAD_BEEF, ~pc};
    endfunction

    function automatic rec_t mk_rec(input logic [1:0] w, input logic e, input logic [31:0] pc);
        rec_t r;
        r.warp = w; r.entry = e; r.pc = pc; r.inst = mk_inst(pc);
        return r;
    endfunction

    // Record every fire seen by fetch, sampled mid-cycle.
    always @(negedge clk) begin
        if (bif.selectedPacketValid_o === 1'b1) begin
            rec_t r;
            r.warp  = bif.selectedWarp_o;
            r.entry = bif.selectedEntry_o;
            r.pc    = bif.issuePC_o;
            r.inst  = bif.issueInst_o;
            obs_q.push_back(r);
            $display("fire: warp=%0d entry=%0d pc=%h", r.warp, r.entry, r.pc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [1:0] w, input logic [31:0] pc);
        bif.instWarp_i         = w;
        bif.instPacket0Valid_i = 1'b1;
        bif.instPacket0_i      = {mk_inst(pc), pc};
        bif.instPacket1Valid_i = 1'b1;
        bif.instPacket1_i      = {mk_inst(pc + 32'd1), pc + 32'd1};
        tick();
        bif.instPacket0Valid_i = 1'b0;
        bif.instPacket1Valid_i = 1'b0;
        $display("write: warp=%0d pc=%h", w, pc);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        @(negedge clk);
        n_cmp++; if (bif.issueValid_o !== 1'b0) begin n_fail++; $display("FAIL reset_issueValid got=%b exp=0", bif.issueValid_o); end
        n_cmp++; if (bif.selectedPacketValid_o !== 1'b0) begin n_fail++; $display("FAIL reset_selValid got=%b exp=0", bif.selectedPacketValid_o); end
        n_cmp++; if (bif.bufValid_o !== 8'h00) begin n_fail++; $display("FAIL reset_bufValid got=%h exp=00", bif.bufValid_o); end
        n_cmp++; if (bif.overflow_o !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got=%b exp=0", bif.overflow_o); end
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic_issue();
        rec_t e, o;
        apply_reset();
        bif.issueReady_i = 1'b0;
        obs_q.delete(); exp_q.delete();
        do_write(2'd2, 32'h10);
        @(negedge clk);
        n_cmp++; if (bif.issueValid_o !== 1'b1) begin n_fail++; $display("FAIL basic_issueValid got=%b exp=1", bif.issueValid_o); end
        n_cmp++; if (bif.issueWarp_o !== 2'd2) begin n_fail++; $display("FAIL basic_issueWarp got=%0d exp=2", bif.issueWarp_o); end
        n_cmp++; if (bif.issuePC_o !== 32'h10) begin n_fail++; $display("FAIL basic_issuePC got=%h exp=10", bif.issuePC_o); end
        n_cmp++; if (bif.issueInst_o !== mk_inst(32'h10)) begin n_fail++; $display("FAIL basic_issueInst got=%h exp=%h", bif.issueInst_o, mk_inst(32'h10)); end
        n_cmp++; if (bif.bufValid_o !== 8'h44) begin n_fail++; $display("FAIL basic_bufValid got=%h exp=44", bif.bufValid_o); end
        tick();
        exp_q.push_back(mk_rec(2'd2, 1'b0, 32'h10));
        exp_q.push_back(mk_rec(2'd2, 1'b1, 32'h11));
        bif.issueReady_i = 1'b1;
        tick(); tick();
        bif.issueReady_i = 1'b0;
        @(negedge clk);
        n_cmp++; if (bif.bufValid_o !== 8'h00) begin n_fail++; $display("FAIL basic_drained got=%h exp=00", bif.bufValid_o); end
        n_cmp++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL basic_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_cmp++; if (o !== e) begin n_fail++; $display("FAIL basic_fire got=w%0d e%0d pc=%h inst=%h exp=w%0d e%0d pc=%h inst=%h", o.warp, o.entry, o.pc, o.inst, e.warp, e.entry, e.pc, e.inst); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_round_robin();
        rec_t e, o;
        apply_reset();
        bif.issueReady_i = 1'b0;
        do_write(2'd0, 32'h100);
        do_write(2'd1, 32'h200);
        do_write(2'd3, 32'h300);
        obs_q.delete(); exp_q.delete();
        // Pointer moves after every fire, so warps interleave and wrap 3->0.
        exp_q.push_back(mk_rec(2'd0, 1'b0, 32'h100));
        exp_q.push_back(mk_rec(2'd1, 1'b0, 32'h200));
        exp_q.push_back(mk_rec(2'd3, 1'b0, 32'h300));
        exp_q.push_back(mk_rec(2'd0, 1'b1, 32'h101));
        exp_q.push_back(mk_rec(2'd1, 1'b1, 32'h201));
        exp_q.push_back(mk_rec(2'd3, 1'b1, 32'h301));
        bif.issueReady_i = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        bif.issueReady_i = 1'b0;
        @(negedge clk);
        n_cmp++; if (bif.bufValid_o !== 8'h00) begin n_fail++; $display("FAIL rr_drained got=%h exp=00", bif.bufValid_o); end
        n_cmp++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rr_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_cmp++; if (o !== e) begin n_fail++; $display("FAIL rr_fire got=w%0d e%0d pc=%h exp=w%0d e%0d pc=%h", o.warp, o.entry, o.pc, e.warp, e.entry, e.pc); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_warp_ready();
        rec_t e, o;
        apply_reset();
        bif.issueReady_i = 1'b0;
        bif.warpReady_i  = 4'b1101;
        do_write(2'd1, 32'h400);
        do_write(2'd2, 32'h500);
        obs_q.delete(); exp_q.delete();
        exp_q.push_back(mk_rec(2'd2, 1'b0, 32'h500));
        exp_q.push_back(mk_rec(2'd2, 1'b1, 32'h501));
        exp_q.push_back(mk_rec(2'd1, 1'b0, 32'h400));
        exp_q.push_back(mk_rec(2'd1, 1'b1, 32'h401));
        bif.issueReady_i = 1'b1;
        tick(); tick();
        @(negedge clk);
        n_cmp++; if (bif.issueValid_o !== 1'b0) begin n_fail++; $display("FAIL ready_blocked got=%b exp=0", bif.issueValid_o); end
        n_cmp++; if (bif.bufValid_o !== 8'h22) begin n_fail++; $display("FAIL ready_bufValid got=%h exp=22", bif.bufValid_o); end
        tick();
        bif.warpReady_i = 4'hF;
        tick(); tick();
        bif.issueReady_i = 1'b0;
        @(negedge clk);
        n_cmp++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL ready_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_cmp++; if (o !== e) begin n_fail++; $display("FAIL ready_fire got=w%0d e%0d pc=%h exp=w%0d e%0d pc=%h", o.warp, o.entry, o.pc, e.warp, e.entry, e.pc); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_flush();
        apply_reset();
        bif.issueReady_i = 1'b0;
        do_write(2'd0, 32'h600);
        obs_q.delete();
        bif.reconv_i = 1'b1; bif.reconvWarp_i = 2'd0; bif.issueReady_i = 1'b1;
        @(negedge clk);
        n_cmp++; if (bif.selectedPacketValid_o !== 1'b0) begin n_fail++; $display("FAIL flush_nofire got=%b exp=0", bif.selectedPacketValid_o); end
        n_cmp++; if (bif.issueValid_o !== 1'b0) begin n_fail++; $display("FAIL flush_issueValid got=%b exp=0", bif.issueValid_o); end
        tick();
        bif.reconv_i = 1'b0; bif.issueReady_i = 1'b0;
        @(negedge clk);
        n_cmp++; if (bif.bufValid_o !== 8'h00) begin n_fail++; $display("FAIL flush_cleared got=%h exp=00", bif.bufValid_o); end
        // Two flushes on different warps in one cycle.
        tick();
        do_write(2'd1, 32'h610);
        do_write(2'd2, 32'h620);
        bif.reconv_i = 1'b1; bif.reconvWarp_i = 2'd2;
        bif.ctaExit_i = 1'b1; bif.exitWarp_i = 2'd1;
        tick();
        bif.reconv_i = 1'b0; bif.ctaExit_i = 1'b0;
        @(negedge clk);
        n_cmp++; if (bif.bufValid_o !== 8'h00) begin n_fail++; $display("FAIL flush_dual got=%h exp=00", bif.bufValid_o); end
        // Flush beats a same-cycle write to the same warp, without error.
        tick();
        bif.ctaExit_i = 1'b1; bif.exitWarp_i = 2'd3;
        do_write(2'd3, 32'h630);
        bif.ctaExit_i = 1'b0;
        @(negedge clk);
        n_cmp++; if (bif.bufValid_o !== 8'h00) begin n_fail++; $display("FAIL flush_vs_write got=%h exp=00", bif.bufValid_o); end
        n_cmp++; if (bif.overflow_o !== 1'b0) begin n_fail++; $display("FAIL flush_vs_write_ovf got=%b exp=0", bif.overflow_o); end
        n_cmp++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL flush_fires got=%0d exp=0", obs_q.size()); end
        obs_q.delete();
        tick();
    endtask

    task automatic test_overflow();
        rec_t e, o;
        apply_reset();
        bif.issueReady_i = 1'b0;
        obs_q.delete(); exp_q.delete();
        do_write(2'd3, 32'h700);
        exp_q.push_back(mk_rec(2'd3, 1'b0, 32'h700));
        bif.issueReady_i = 1'b1;
        tick();
        bif.issueReady_i = 1'b0;
        do_write(2'd3, 32'h900);
        @(negedge clk);
        n_cmp++; if (bif.overflow_o !== 1'b1) begin n_fail++; $display("FAIL ovf_set got=%b exp=1", bif.overflow_o); end
        n_cmp++; if (bif.bufValid_o !== 8'h80) begin n_fail++; $display("FAIL ovf_bufValid got=%h exp=80", bif.bufValid_o); end
        tick();
        exp_q.push_back(mk_rec(2'd3, 1'b1, 32'h701));
        bif.issueReady_i = 1'b1;
        tick();
        bif.issueReady_i = 1'b0;
        tick(); tick(); tick();
        @(negedge clk);
        n_cmp++; if (bif.overflow_o !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got=%b exp=1", bif.overflow_o); end
        // Reset mid-operation discards a loaded warp and clears the flag.
        tick();
        do_write(2'd2, 32'h800);
        apply_reset();
        @(negedge clk);
        n_cmp++; if (bif.bufValid_o !== 8'h00) begin n_fail++; $display("FAIL ovf_reset_buf got=%h exp=00", bif.bufValid_o); end
        n_cmp++; if (bif.overflow_o !== 1'b0) begin n_fail++; $display("FAIL ovf_reset_flag got=%b exp=0", bif.overflow_o); end
        // Same-warp issue+write drops the write; different-warp write proceeds.
        tick();
        do_write(2'd0, 32'hA00);
        bif.issueReady_i = 1'b1;
        exp_q.push_back(mk_rec(2'd0, 1'b0, 32'hA00));
        do_write(2'd0, 32'hB00);
        exp_q.push_back(mk_rec(2'd0, 1'b1, 32'hA01));
        do_write(2'd1, 32'hC00);
        exp_q.push_back(mk_rec(2'd1, 1'b0, 32'hC00));
        exp_q.push_back(mk_rec(2'd1, 1'b1, 32'hC01));
        tick(); tick();
        bif.issueReady_i = 1'b0;
        @(negedge clk);
        n_cmp++; if (bif.overflow_o !== 1'b1) begin n_fail++; $display("FAIL ovf_issue_write got=%b exp=1", bif.overflow_o); end
        n_cmp++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL ovf_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_cmp++; if (o !== e) begin n_fail++; $display("FAIL ovf_fire got=w%0d e%0d pc=%h inst=%h exp=w%0d e%0d pc=%h inst=%h", o.warp, o.entry, o.pc, o.inst, e.warp, e.entry, e.pc, e.inst); end
        end
        exp_q.delete(); obs_q.delete();
        tick();
    endtask

    task automatic test_stall();
        rec_t e, o;
        apply_reset();
        bif.issueReady_i = 1'b0;
        do_write(2'd0, 32'hD00);
        do_write(2'd1, 32'hE00);
        obs_q.delete(); exp_q.delete();
        bif.stall_i = 1'b1; bif.issueReady_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i == 0) begin
                bif.instWarp_i = 2'd2;
                bif.instPacket0Valid_i = 1'b1; bif.instPacket0_i = {mk_inst(32'hF00), 32'hF00};
                bif.instPacket1Valid_i = 1'b1; bif.instPacket1_i = {mk_inst(32'hF01), 32'hF01};
            end
            @(negedge clk);
            n_cmp++; if (bif.selectedPacketValid_o !== 1'b0) begin n_fail++; $display("FAIL stall_sel[%0d] got=%b exp=0", i, bif.selectedPacketValid_o); end
            n_cmp++; if (bif.bufValid_o !== 8'h33) begin n_fail++; $display("FAIL stall_buf[%0d] got=%h exp=33", i, bif.bufValid_o); end
            n_cmp++; if (bif.issueValid_o !== 1'b1 || bif.issueWarp_o !== 2'd0) begin n_fail++; $display("FAIL stall_cand[%0d] got=%b/%0d exp=1/0", i, bif.issueValid_o, bif.issueWarp_o); end
            tick();
            bif.instPacket0Valid_i = 1'b0; bif.instPacket1Valid_i = 1'b0;
        end
        @(negedge clk);
        n_cmp++; if (bif.bufValid_o !== 8'h33 || bif.overflow_o !== 1'b0) begin n_fail++; $display("FAIL stall_after got=%h/%b exp=33/0", bif.bufValid_o, bif.overflow_o); end
        n_cmp++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL stall_fires got=%0d exp=0", obs_q.size()); end
        obs_q.delete();
        tick();
        bif.stall_i = 1'b0;
        exp_q.push_back(mk_rec(2'd0, 1'b0, 32'hD00));
        exp_q.push_back(mk_rec(2'd1, 1'b0, 32'hE00));
        exp_q.push_back(mk_rec(2'd0, 1'b1, 32'hD01));
        exp_q.push_back(mk_rec(2'd1, 1'b1, 32'hE01));
        for (int i = 0; i < 4; i++) tick();
        bif.issueReady_i = 1'b0;
        @(negedge clk);
        n_cmp++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL stall_resume_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_cmp++; if (o !== e) begin n_fail++; $display("FAIL stall_fire got=w%0d e%0d pc=%h exp=w%0d e%0d pc=%h", o.warp, o.entry, o.pc, e.warp, e.entry, e.pc); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    initial begin
        reset                  = 1'b1;
        bif.stall_i            = 1'b0;
        bif.instWarp_i         = '0;
        bif.instPacket0Valid_i = 1'b0;
        bif.instPacket0_i      = '0;
        bif.instPacket1Valid_i = 1'b0;
        bif.instPacket1_i      = '0;
        bif.warpReady_i        = 4'hF;
        bif.issueReady_i       = 1'b0;
        bif.reconv_i           = 1'b0;
        bif.reconvWarp_i       = '0;
        bif.ctaExit_i          = 1'b0;
        bif.exitWarp_i         = '0;

        test_reset();
        test_basic_issue();
        test_round_robin();
        test_warp_ready();
        test_flush();
        test_overflow();
        test_stall();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
